// File: rtl/fp_issue_ctrl_if.sv
// FP issue request/response channel between the issue controller and the FPU.
// Latency: none, plain wires.
// Backpressure: request held by in_valid until in_ready; response held by out_valid until out_ready.
//
// Ports (master = issuer, slave = FPU):
//   in_valid/in_ready   request handshake
//   op, op_mod, rm      operation, modifier, resolved rounding mode
//   operands            {c,b,a}
//   out_valid/out_ready response handshake
//   result, status      FPU result and {NV,DZ,OF,UF,NX}
interface fp_issue_ctrl_if #(
  parameter int unsigned FLEN = 32,
  parameter int unsigned OP_W = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [OP_W-1:0]        op;
  logic                   op_mod;
  logic [2:0]             rm;
  logic [3*FLEN-1:0]      operands;
  logic                   out_valid;
  logic                   out_ready;
  logic [FLEN-1:0]        result;
  logic [4:0]             status;

  modport master (
    output in_valid, op, op_mod, rm, operands, out_ready,
    input  in_ready, out_valid, result, status
  );

  modport slave (
    input  in_valid, op, op_mod, rm, operands, out_ready,
    output in_ready, out_valid, result, status
  );
endinterface

// File: rtl/fp_issue_ctrl.sv
// Single-outstanding FP op issue controller between the FP decoder and the FPU.
// Latency: accept@T, FPU request@T+1, writeback no earlier than T+3.
// Backpressure: dec_ready_o only in IDLE; request held until fpu.in_ready; result taken only in WAIT.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   dec_*                  decoded op from the decoder (valid/ready)
//   frm_i                  frm CSR, used when the instruction rm field is 111
//   fpu                    request/response channel to the FPU (master side)
//   fp_we_o/int_we_o       one-cycle regfile write strobes with wb_addr_o/wb_data_o
//   fflags_o, fflags_clr_i sticky exception flags and their CSR clear
//   illegal_o              one-cycle pulse on a reserved rounding mode
//   timeout_o              one-cycle pulse when the WAIT watchdog fires
// Build option: define FP_ISSUE_TIMEOUT_EN to enable the WAIT watchdog
// (TIMEOUT_CYCLES); without it the block waits for the FPU indefinitely.
module fp_issue_ctrl #(
  parameter int unsigned FLEN           = 32,
  parameter int unsigned OP_W           = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // decoder side
  input  logic              dec_valid_i,
  output logic              dec_ready_o,
  input  logic [OP_W-1:0]   dec_op_i,
  input  logic              dec_op_mod_i,
  input  logic [2:0]        dec_rm_i,
  input  logic [4:0]        dec_rd_i,
  input  logic              dec_fp_wb_i,
  input  logic              dec_int_wb_i,
  input  logic [FLEN-1:0]   op_a_i,
  input  logic [FLEN-1:0]   op_b_i,
  input  logic [FLEN-1:0]   op_c_i,
  input  logic [2:0]        frm_i,
  // FPU side
  fp_issue_ctrl_if.master   fpu,
  // writeback side
  output logic              fp_we_o,
  output logic              int_we_o,
  output logic [4:0]        wb_addr_o,
  output logic [FLEN-1:0]   wb_data_o,
  output logic [4:0]        fflags_o,
  input  logic              fflags_clr_i,
  output logic              illegal_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic              op_mod;
    logic [2:0]        rm;
    logic [4:0]        rd;
    logic              fp_wb;
    logic              int_wb;
    logic [3*FLEN-1:0] operands;
  } req_t;

  state_e          state_q, state_d;
  req_t            req_q;
  logic [FLEN-1:0] res_q;
  logic [4:0]      stat_q;
  logic [4:0]      fflags_q;
  logic            illegal_q;

  logic [2:0]      rm_res;
  logic            rm_bad;
  logic            accept;
  logic            to_fire;

  // 111 selects the dynamic mode; 101/110/111 after resolution are reserved.
  assign rm_res = (dec_rm_i == 3'b111) ? frm_i : dec_rm_i;
  assign rm_bad = rm_res[2] & (rm_res[1] | rm_res[0]);
  assign accept = (state_q == IDLE) && dec_valid_i;

  always_comb begin
    state_d       = state_q;
    dec_ready_o   = 1'b0;
    fpu.in_valid  = 1'b0;
    fpu.out_ready = 1'b0;
    fp_we_o       = 1'b0;
    int_we_o      = 1'b0;
    wb_addr_o     = '0;
    wb_data_o     = '0;
    unique case (state_q)
      IDLE: begin
        dec_ready_o = 1'b1;
        if (dec_valid_i && !rm_bad) state_d = ISSUE;
      end
      ISSUE: begin
        fpu.in_valid = 1'b1;
        if (fpu.in_ready) state_d = WAIT;
      end
      WAIT: begin
        fpu.out_ready = 1'b1;
        // A result arriving on the watchdog's last cycle still wins.
        if (fpu.out_valid)  state_d = WB;
        else if (to_fire)   state_d = IDLE;
      end
      WB: begin
        // Integer destination takes precedence when both selects are set.
        int_we_o  = req_q.int_wb;
        fp_we_o   = req_q.fp_wb & ~req_q.int_wb;
        wb_addr_o = req_q.rd;
        wb_data_o = res_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      req_q     <= '0;
      res_q     <= '0;
      stat_q    <= '0;
      fflags_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= accept && rm_bad;
      if (accept && !rm_bad) begin
        req_q.op       <= dec_op_i;
        req_q.op_mod   <= dec_op_mod_i;
        req_q.rm       <= rm_res;
        req_q.rd       <= dec_rd_i;
        req_q.fp_wb    <= dec_fp_wb_i;
        req_q.int_wb   <= dec_int_wb_i;
        req_q.operands <= {op_c_i, op_b_i, op_a_i};
      end
      if (state_q == WAIT && fpu.out_valid) begin
        res_q  <= fpu.result;
        stat_q <= fpu.status;
      end
      // A clear coincident with writeback drops old flags but keeps this op's.
      if (state_q == WB)    fflags_q <= (fflags_clr_i ? 5'b0 : fflags_q) | stat_q;
      else if (fflags_clr_i) fflags_q <= 5'b0;
    end
  end

`ifdef FP_ISSUE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  // Fires on the edge ending the TIMEOUT_CYCLES-th WAIT cycle without a result.
  assign to_fire = (state_q == WAIT) && !fpu.out_valid &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= to_fire;
      if (state_q == WAIT && !to_fire) cnt_q <= cnt_q + 1'b1;
      else                             cnt_q <= '0;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign to_fire   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign fpu.op       = req_q.op;
  assign fpu.op_mod   = req_q.op_mod;
  assign fpu.rm       = req_q.rm;
  assign fpu.operands = req_q.operands;
  assign fflags_o     = fflags_q;
  assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_fp_issue_ctrl.sv
module tb_fp_issue_ctrl;
  localparam int FLEN = 32;
  localparam int OP_W = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            dec_valid_i;
  logic            dec_ready_o;
  logic [3:0]      dec_op_i;
  logic            dec_op_mod_i;
  logic [2:0]      dec_rm_i;
  logic [4:0]      dec_rd_i;
  logic            dec_fp_wb_i;
  logic            dec_int_wb_i;
  logic [31:0]     op_a_i, op_b_i, op_c_i;
  logic [2:0]      frm_i;
  logic            fp_we_o, int_we_o;
  logic [4:0]      wb_addr_o;
  logic [31:0]     wb_data_o;
  logic [4:0]      fflags_o;
  logic            fflags_clr_i;
  logic            illegal_o;
  logic            timeout_o;

  fp_issue_ctrl_if #(.FLEN(FLEN), .OP_W(OP_W)) fpu_if ();

  fp_issue_ctrl #(.FLEN(FLEN), .OP_W(OP_W), .TIMEOUT_CYCLES(64)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .dec_valid_i  (dec_valid_i),
    .dec_ready_o  (dec_ready_o),
    .dec_op_i     (dec_op_i),
    .dec_op_mod_i (dec_op_mod_i),
    .dec_rm_i     (dec_rm_i),
    .dec_rd_i     (dec_rd_i),
    .dec_fp_wb_i  (dec_fp_wb_i),
    .dec_int_wb_i (dec_int_wb_i),
    .op_a_i       (op_a_i),
    .op_b_i       (op_b_i),
    .op_c_i       (op_c_i),
    .frm_i        (frm_i),
    .fpu          (fpu_if.master),
    .fp_we_o      (fp_we_o),
    .int_we_o     (int_we_o),
    .wb_addr_o    (wb_addr_o),
    .wb_data_o    (wb_data_o),
    .fflags_o     (fflags_o),
    .fflags_clr_i (fflags_clr_i),
    .illegal_o    (illegal_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rm;
    logic [2:0]  frm;
    logic [4:0]  rd;
    logic        fp_wb;
    logic        int_wb;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  st;
    logic [2:0]  exp_rm;
    logic        exp_ill;
    logic        exp_fp_we;
    logic        exp_int_we;
  } vec_t;

  localparam logic [31:0] OPC = 32'hC0FFEE00;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic [4:0] ff_exp = 5'b0;
  vec_t vecs [8];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  // Present one op to the decoder port for a single edge.
  task automatic present(input logic [3:0] op, input logic [2:0] rm, input logic [2:0] frm,
                         input logic [4:0] rd, input logic fpw, input logic intw,
                         input logic [31:0] a, input logic [31:0] b);
    dec_valid_i  = 1'b1;
    dec_op_i     = op;
    dec_op_mod_i = 1'b0;
    dec_rm_i     = rm;
    frm_i        = frm;
    dec_rd_i     = rd;
    dec_fp_wb_i  = fpw;
    dec_int_wb_i = intw;
    op_a_i       = a;
    op_b_i       = b;
    op_c_i       = OPC;
    tick();
    dec_valid_i  = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    chk({t, ".dec_ready"}, dec_ready_o, 1'b1);
    present(v.op, v.rm, v.frm, v.rd, v.fp_wb, v.int_wb, v.a, v.b);
    chk({t, ".illegal"}, illegal_o, v.exp_ill);
    chk({t, ".in_valid"}, fpu_if.in_valid, !v.exp_ill);
    if (v.exp_ill) begin
      chk({t, ".ready_after_ill"}, dec_ready_o, 1'b1);
      tick();
      chk({t, ".ill_pulse_end"}, illegal_o, 1'b0);
      chk({t, ".no_issue"}, fpu_if.in_valid, 1'b0);
      chk({t, ".fflags"}, fflags_o, ff_exp);
      return;
    end
    chk({t, ".rm"}, fpu_if.rm, v.exp_rm);
    chk({t, ".op"}, fpu_if.op, v.op);
    chk({t, ".operands"}, fpu_if.operands, {OPC, v.b, v.a});
    fpu_if.in_ready = 1'b1;
    tick();
    fpu_if.in_ready  = 1'b0;
    chk({t, ".out_ready"}, fpu_if.out_ready, 1'b1);
    chk({t, ".in_valid_drop"}, fpu_if.in_valid, 1'b0);
    fpu_if.out_valid = 1'b1;
    fpu_if.result    = v.res;
    fpu_if.status    = v.st;
    tick();
    fpu_if.out_valid = 1'b0;
    chk({t, ".fp_we"}, fp_we_o, v.exp_fp_we);
    chk({t, ".int_we"}, int_we_o, v.exp_int_we);
    if (v.exp_fp_we || v.exp_int_we) begin
      chk({t, ".wb_addr"}, wb_addr_o, v.rd);
      chk({t, ".wb_data"}, wb_data_o, v.res);
    end
    ff_exp = ff_exp | v.st;
    tick();
    chk({t, ".we_pulse_end"}, {fp_we_o, int_we_o}, 2'b00);
    chk({t, ".fflags"}, fflags_o, ff_exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    rst_ni = 1'b0;
    dec_valid_i = 1'b0; dec_op_i = '0; dec_op_mod_i = 1'b0; dec_rm_i = '0; dec_rd_i = '0;
    dec_fp_wb_i = 1'b0; dec_int_wb_i = 1'b0; op_a_i = '0; op_b_i = '0; op_c_i = '0;
    frm_i = '0; fflags_clr_i = 1'b0;
    fpu_if.in_ready = 1'b0; fpu_if.out_valid = 1'b0; fpu_if.result = '0; fpu_if.status = '0;

    //            op     rm      frm     rd     fpw   intw  a             b             res           st        exp_rm  ill   fpwe  intwe
    vecs[0] = '{4'd2,  3'b000, 3'b000, 5'd3,  1'b1, 1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 5'b00001, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{4'd3,  3'b111, 3'b010, 5'd7,  1'b1, 1'b0, 32'h40000000, 32'h40400000, 32'h40C00000, 5'b00000, 3'b010, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{4'd2,  3'b111, 3'b101, 5'd9,  1'b1, 1'b0, 32'h11111111, 32'h22222222, 32'h0,        5'b11111, 3'b000, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{4'd11, 3'b001, 3'b000, 5'd10, 1'b0, 1'b1, 32'h42280000, 32'h0,        32'h0000002A, 5'b00100, 3'b001, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{4'd4,  3'b110, 3'b000, 5'd4,  1'b1, 1'b0, 32'h1,        32'h2,        32'h0,        5'b11111, 3'b000, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{4'd8,  3'b010, 3'b000, 5'd5,  1'b0, 1'b0, 32'h3F800000, 32'h3F800000, 32'h00000001, 5'b00010, 3'b010, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{4'd5,  3'b111, 3'b100, 5'd31, 1'b1, 1'b0, 32'h40800000, 32'h0,        32'h40000000, 5'b01000, 3'b100, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{4'd2,  3'b111, 3'b111, 5'd6,  1'b1, 1'b0, 32'h5,        32'h6,        32'h0,        5'b11111, 3'b000, 1'b1, 1'b0, 1'b0};

    tick(); tick(); tick();
    // Reset values, observed while reset is still asserted and after release.
    chk("rst.dec_ready", dec_ready_o, 1'b1);
    chk("rst.outs", {fpu_if.in_valid, fpu_if.out_ready, fp_we_o, int_we_o, illegal_o, timeout_o}, 6'b0);
    chk("rst.fflags", fflags_o, 5'b0);
    chk("rst.payload", {fpu_if.op, fpu_if.rm, fpu_if.operands, wb_addr_o, wb_data_o}, '0);
    rst_ni = 1'b1;
    tick();
    chk("rst.idle", dec_ready_o, 1'b1);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // FPU stalls the request for 5 cycles; a second decoder valid must be ignored.
    present(4'd3, 3'b011, 3'b000, 5'd12, 1'b1, 1'b0, 32'hAAAA0001, 32'hBBBB0002);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d.in_valid", c), fpu_if.in_valid, 1'b1);
      chk($sformatf("stall%0d.dec_ready", c), dec_ready_o, 1'b0);
      chk($sformatf("stall%0d.payload", c), {fpu_if.op, fpu_if.rm, fpu_if.operands},
          {4'd3, 3'b011, OPC, 32'hBBBB0002, 32'hAAAA0001});
      dec_valid_i = 1'b1; dec_op_i = 4'd9; dec_rd_i = 5'd1; op_a_i = 32'hDEADBEEF;
      tick();
      dec_valid_i = 1'b0;
    end
    fpu_if.in_ready = 1'b1;
    tick();
    fpu_if.in_ready = 1'b0;
    fpu_if.out_valid = 1'b1; fpu_if.result = 32'h12345678; fpu_if.status = 5'b00000;
    tick();
    fpu_if.out_valid = 1'b0;
    chk("stall.fp_we", fp_we_o, 1'b1);
    chk("stall.wb_addr", wb_addr_o, 5'd12);
    chk("stall.wb_data", wb_data_o, 32'h12345678);
    tick();
    chk("stall.back_idle", dec_ready_o, 1'b1);

    // fflags clear coincident with a writeback that raises NV.
    present(4'd4, 3'b000, 3'b000, 5'd2, 1'b1, 1'b0, 32'h0, 32'h0);
    fpu_if.in_ready = 1'b1;
    tick();
    fpu_if.in_ready = 1'b0;
    fpu_if.out_valid = 1'b1; fpu_if.result = 32'h7FC00000; fpu_if.status = 5'b10000;
    tick();
    fpu_if.out_valid = 1'b0;
    chk("clr.pre_fflags", fflags_o, ff_exp);
    fflags_clr_i = 1'b1;
    tick();
    fflags_clr_i = 1'b0;
    ff_exp = 5'b10000;
    chk("clr.fflags", fflags_o, ff_exp);

    // Watchdog behaviour while the FPU never answers.
    present(4'd2, 3'b000, 3'b000, 5'd8, 1'b1, 1'b0, 32'h1, 32'h2);
    fpu_if.in_ready = 1'b1;
    tick();
    fpu_if.in_ready = 1'b0;
`ifdef FP_ISSUE_TIMEOUT_EN
    n = 1;
    while (!timeout_o && n < 200) begin
      tick();
      n++;
    end
    chk("to.fired_at", n, 65);
    chk("to.no_we", {fp_we_o, int_we_o}, 2'b00);
    chk("to.idle", dec_ready_o, 1'b1);
    chk("to.fflags", fflags_o, ff_exp);
    tick();
    chk("to.pulse_end", timeout_o, 1'b0);
`else
    n = 0;
    for (int c = 0; c < 80; c++) begin
      if (timeout_o || !fpu_if.out_ready) n++;
      tick();
    end
    chk("to.never", n, 0);
    fpu_if.out_valid = 1'b1; fpu_if.result = 32'h0BADF00D; fpu_if.status = 5'b00000;
    tick();
    fpu_if.out_valid = 1'b0;
    chk("to.late_wb", {fp_we_o, wb_data_o}, {1'b1, 32'h0BADF00D});
    tick();
`endif

    // Reset while waiting for the FPU drops the op without a writeback.
    present(4'd2, 3'b000, 3'b000, 5'd14, 1'b1, 1'b0, 32'h3, 32'h4);
    fpu_if.in_ready = 1'b1;
    tick();
    fpu_if.in_ready = 1'b0;
    chk("rstw.in_wait", fpu_if.out_ready, 1'b1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    chk("rstw.idle", {dec_ready_o, fpu_if.in_valid, fpu_if.out_ready}, 3'b100);
    chk("rstw.fflags", fflags_o, 5'b0);
    fpu_if.out_valid = 1'b1; fpu_if.result = 32'hFFFFFFFF; fpu_if.status = 5'b11111;
    tick();
    fpu_if.out_valid = 1'b0;
    chk("rstw.no_we", {fp_we_o, int_we_o}, 2'b00);
    tick();
    chk("rstw.no_we2", {fp_we_o, int_we_o, fflags_o}, 7'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
